// File: rtl/bus_io_pkg.sv
// Shared constants for the bus_io_responder block.
//   - register offsets within the 16-word window selected by ADDR[9:4]
//   - STATUS bit positions and CTRL bit positions
//   - timer FSM state encoding
//   - pack_status(): assembles the STATUS read word
package bus_io_pkg;

    localparam int DATA_W = 32;

    // Register offsets (ADDR[3:0])
    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h1;
    localparam logic [3:0] REG_TLOAD  = 4'h2;
    localparam logic [3:0] REG_TVALUE = 4'h3;
    localparam logic [3:0] REG_CTRL   = 4'h4;

    // STATUS bit positions
    localparam int ST_COUNT_LSB = 0;
    localparam int ST_COUNT_W   = 5;
    localparam int ST_EMPTY_BIT = 5;
    localparam int ST_FULL_BIT  = 6;
    localparam int ST_OVF_BIT   = 7;
    localparam int ST_IRQ_BIT   = 8;

    // CTRL bit positions; the clear bit is a write-only strobe
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_AR_BIT  = 1;
    localparam int CTRL_CLR_BIT = 31;

    typedef enum logic [1:0] {
        TMR_IDLE    = 2'd0,
        TMR_RUN     = 2'd1,
        TMR_EXPIRED = 2'd2
    } timer_state_e;

    function automatic logic [DATA_W-1:0] pack_status(
        input logic       irq_pend,
        input logic       ovf,
        input logic       full,
        input logic       empty,
        input logic [4:0] count
    );
        logic [DATA_W-1:0] s;
        s = '0;
        s[ST_COUNT_LSB +: ST_COUNT_W] = count;
        s[ST_EMPTY_BIT] = empty;
        s[ST_FULL_BIT]  = full;
        s[ST_OVF_BIT]   = ovf;
        s[ST_IRQ_BIT]   = irq_pend;
        return s;
    endfunction

endpackage

// File: rtl/bus_io_responder_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset (empties the FIFO)
//   push_i   : write wdata_i this edge (caller guarantees !full_o || pop_i)
//   wdata_i  : write data
//   pop_i    : drop the head entry this edge (caller guarantees !empty_o)
//   rdata_o  : head entry, valid whenever empty_o is low
//   empty_o  : no entries
//   full_o   : DEPTH entries
//   count_o  : occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    // Storage carries no reset; stale words are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;

endmodule

// File: rtl/bus_io_responder.sv
// bus_io_responder: memory-mapped I/O block with an output stream FIFO and
// a down-counting timer with interrupt.
//   clock / reset  : single clock, synchronous active-high reset
//   cs, we, ADDR   : bus cycle qualifiers; block responds when ADDR[9:4]==BASE
//   Data_BUS_WRITE : write data
//   Data_BUS_READ  : read data, valid for one cycle after a read, 0 otherwise
//   out_data/out_valid/out_ready : stream output. out_valid is high while the
//                    FIFO holds data; a word transfers on any edge where
//                    out_valid && out_ready are both high. out_data shows the
//                    head word (first-word-fall-through).
//   irq            : registered copy of the sticky timer interrupt flag
// Register map: 0 DATA (W push), 1 STATUS (R), 2 TLOAD (R/W), 3 TVALUE (R),
// 4 CTRL (R/W: bit0 en, bit1 auto-reload, write bit31=1 clears ovf/irq_pend).
module bus_io_responder
    import bus_io_pkg::*;
#(
    parameter logic [5:0] BASE       = 6'h3F,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cs,
    input  logic              we,
    input  logic [9:0]        ADDR,
    input  logic [DATA_W-1:0] Data_BUS_WRITE,
    output logic [DATA_W-1:0] Data_BUS_READ,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // ---------------- bus decode ----------------
    logic [3:0] ofs;
    logic       sel;
    logic       bus_wr;
    logic       bus_rd;
    logic       wr_data;
    logic       wr_tload;
    logic       wr_ctrl;
    logic       clr_flags;

    assign ofs       = ADDR[3:0];
    assign sel       = cs && (ADDR[9:4] == BASE);
    assign bus_wr    = sel && we;
    assign bus_rd    = sel && !we;
    assign wr_data   = bus_wr && (ofs == REG_DATA);
    assign wr_tload  = bus_wr && (ofs == REG_TLOAD);
    assign wr_ctrl   = bus_wr && (ofs == REG_CTRL);
    assign clr_flags = wr_ctrl && Data_BUS_WRITE[CTRL_CLR_BIT];

    // ---------------- stream FIFO ----------------
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic [4:0]       count5;
    logic             fifo_pop;
    logic             fifo_push;
    logic             fifo_drop;

    assign fifo_pop  = !fifo_empty && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign fifo_push = wr_data && (!fifo_full || fifo_pop);
    assign fifo_drop = wr_data && fifo_full && !fifo_pop;
    assign count5    = 5'(fifo_count);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .wdata_i (Data_BUS_WRITE),
        .pop_i   (fifo_pop),
        .rdata_o (out_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign out_valid = !fifo_empty;

    // ---------------- control / status registers ----------------
    logic [DATA_W-1:0] tload_q;
    logic [DATA_W-1:0] tvalue_q;
    logic              en_q, en_d;
    logic              ar_q, ar_d;
    logic              ovf_q, ovf_d;
    logic              irq_pend_q, irq_pend_d;
    logic              irq_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    timer_state_e      tmr_state_q;
    logic              en_rise;
    logic              tmr_expire;

    always_comb begin
        en_d = en_q;
        ar_d = ar_q;
        if (wr_ctrl) begin
            en_d = Data_BUS_WRITE[CTRL_EN_BIT];
            ar_d = Data_BUS_WRITE[CTRL_AR_BIT];
        end
    end

    assign en_rise = en_d && !en_q;

    // The timer only counts when nothing higher priority (TLOAD write,
    // disable, enable reload) claims the edge. A RUN state with TVALUE of
    // 0 or 1 expires: 1 steps to 0, 0 (TLOAD=0) stays at 0.
    assign tmr_expire = !wr_tload && en_d && !en_rise &&
                        (tmr_state_q == TMR_RUN) && (tvalue_q <= 32'd1);

    // Set beats clear when both happen on the same edge.
    always_comb begin
        irq_pend_d = irq_pend_q;
        if (clr_flags)  irq_pend_d = 1'b0;
        if (tmr_expire) irq_pend_d = 1'b1;
        ovf_d = ovf_q;
        if (clr_flags)  ovf_d = 1'b0;
        if (fifo_drop)  ovf_d = 1'b1;
    end

    always_comb begin
        rdata_d = '0;
        if (bus_rd) begin
            case (ofs)
                REG_STATUS: rdata_d = pack_status(irq_pend_q, ovf_q, fifo_full,
                                                  fifo_empty, count5);
                REG_TLOAD:  rdata_d = tload_q;
                REG_TVALUE: rdata_d = tvalue_q;
                REG_CTRL:   rdata_d = {30'b0, ar_q, en_q};
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tload_q    <= '0;
            en_q       <= 1'b0;
            ar_q       <= 1'b0;
            ovf_q      <= 1'b0;
            irq_pend_q <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (wr_tload) begin
                tload_q <= Data_BUS_WRITE;
            end
            en_q       <= en_d;
            ar_q       <= ar_d;
            ovf_q      <= ovf_d;
            irq_pend_q <= irq_pend_d;
            irq_q      <= irq_pend_q;
            rdata_q    <= rdata_d;
        end
    end

    // ---------------- timer FSM ----------------
    // IDLE: disabled, TVALUE held. RUN: counting down. EXPIRED: parked at 0
    // until auto-reload, a TLOAD write, or a fresh enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmr_state_q <= TMR_IDLE;
            tvalue_q    <= '0;
        end else if (wr_tload) begin
            tvalue_q    <= Data_BUS_WRITE;
            tmr_state_q <= en_q ? TMR_RUN : TMR_IDLE;
        end else if (!en_d) begin
            tmr_state_q <= TMR_IDLE;
        end else if (en_rise) begin
            tvalue_q    <= tload_q;
            tmr_state_q <= TMR_RUN;
        end else begin
            case (tmr_state_q)
                TMR_RUN: begin
                    if (tvalue_q <= 32'd1) begin
                        tvalue_q    <= '0;
                        tmr_state_q <= TMR_EXPIRED;
                    end else begin
                        tvalue_q <= tvalue_q - 32'd1;
                    end
                end
                TMR_EXPIRED: begin
                    if (ar_q) begin
                        tvalue_q    <= tload_q;
                        tmr_state_q <= TMR_RUN;
                    end
                end
                default: begin
                    // Enabled while IDLE is unreachable; resume counting.
                    tmr_state_q <= TMR_RUN;
                end
            endcase
        end
    end

    assign Data_BUS_READ = rdata_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_bus_io_responder.sv
// Testbench for bus_io_responder: directed scenarios followed by random bus
// traffic, checked against a behavioural model and a stream scoreboard.
module tb_bus_io_responder;

    localparam logic [5:0] BASE  = 6'h3F;
    localparam int         DEPTH = 8;

    localparam logic [3:0] O_DATA   = 4'h0;
    localparam logic [3:0] O_STATUS = 4'h1;
    localparam logic [3:0] O_TLOAD  = 4'h2;
    localparam logic [3:0] O_TVALUE = 4'h3;
    localparam logic [3:0] O_CTRL   = 4'h4;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [9:0]  ADDR = '0;
    logic [31:0] Data_BUS_WRITE = '0;
    logic        out_ready = 1'b0;
    logic [31:0] Data_BUS_READ;
    logic [31:0] out_data;
    logic        out_valid;
    logic        irq;

    always #5 clock = ~clock;

    bus_io_responder #(
        .BASE       (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cs             (cs),
        .we             (we),
        .ADDR           (ADDR),
        .Data_BUS_WRITE (Data_BUS_WRITE),
        .Data_BUS_READ  (Data_BUS_READ),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .irq            (irq)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];   // stream words in the order they must leave
    logic [31:0] rd_q[$];    // read responses in issue order

    // Expected observable outputs after the most recent edge (cur) and
    // after the coming edge (nxt).
    bit cur_valid = 0, cur_irq = 0, cur_rd = 0;
    bit nxt_valid = 0, nxt_irq = 0, nxt_rd = 0;

    // ---------------- behavioural model ----------------
    int          m_count   = 0;   // words held in the FIFO
    bit          m_ovf     = 0;
    bit          m_pend    = 0;   // interrupt pending flag
    bit          m_en      = 0;
    bit          m_ar      = 0;
    bit          m_stopped = 0;   // timer parked at zero after expiring
    logic [31:0] m_tload   = '0;
    logic [31:0] m_tvalue  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[4:0] = 5'(m_count);
        s[5]   = (m_count == 0);
        s[6]   = (m_count == DEPTH);
        s[7]   = m_ovf;
        s[8]   = m_pend;
        return s;
    endfunction

    // Applies one clock edge worth of bus/stream activity to the model.
    task automatic model_edge(input bit r, input bit c, input bit w,
                              input logic [9:0] a, input logic [31:0] d, input bit rdy);
        bit          sel, wr, rd, pop, expire, clr, old_ar, en_rise;
        logic [31:0] rv;
        if (r) begin
            m_count = 0; m_ovf = 0; m_pend = 0; m_en = 0; m_ar = 0;
            m_stopped = 0; m_tload = '0; m_tvalue = '0;
            exp_q.delete();
            nxt_valid = 0; nxt_irq = 0; nxt_rd = 0;
            return;
        end
        sel    = c && (a[9:4] == BASE);
        wr     = sel && w;
        rd     = sel && !w;
        expire = 0;
        nxt_irq = m_pend;

        nxt_rd = rd;
        if (rd) begin
            case (a[3:0])
                O_STATUS: rv = model_status();
                O_TLOAD:  rv = m_tload;
                O_TVALUE: rv = m_tvalue;
                O_CTRL:   rv = {30'b0, m_ar, m_en};
                default:  rv = '0;
            endcase
            rd_q.push_back(rv);
        end

        pop = rdy && (m_count > 0);
        if (wr && a[3:0] == O_DATA) begin
            if (m_count < DEPTH || pop) begin
                exp_q.push_back(d);
                m_count++;
            end else begin
                m_ovf = 1;
            end
        end
        if (pop) m_count--;

        clr     = wr && (a[3:0] == O_CTRL) && d[31];
        old_ar  = m_ar;
        en_rise = wr && (a[3:0] == O_CTRL) && d[0] && !m_en;
        if (wr && a[3:0] == O_CTRL) begin
            m_en = d[0];
            m_ar = d[1];
        end
        if (wr && a[3:0] == O_TLOAD) begin
            m_tload = d; m_tvalue = d; m_stopped = 0;
        end else if (!m_en) begin
            // disabled: value held
        end else if (en_rise) begin
            m_tvalue = m_tload; m_stopped = 0;
        end else if (m_stopped) begin
            if (old_ar) begin
                m_tvalue = m_tload; m_stopped = 0;
            end
        end else if (m_tvalue <= 1) begin
            m_tvalue = 0; m_stopped = 1; expire = 1;
        end else begin
            m_tvalue = m_tvalue - 1;
        end

        if (clr) begin
            m_pend = 0;
            m_ovf  = 0;
        end
        if (expire) m_pend = 1;
        nxt_valid = (m_count > 0);
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; inputs hold until the next one.
    task automatic drive(input bit r, input bit c, input bit w,
                         input logic [9:0] a, input logic [31:0] d, input bit rdy);
        cur_valid = nxt_valid;
        cur_irq   = nxt_irq;
        cur_rd    = nxt_rd;
        reset = r; cs = c; we = w; ADDR = a; Data_BUS_WRITE = d; out_ready = rdy;
        model_edge(r, c, w, a, d, rdy);
        @(posedge clock);
        #1;
    endtask

    task automatic wr_reg(input logic [3:0] o, input logic [31:0] d, input bit rdy);
        drive(0, 1, 1, {BASE, o}, d, rdy);
    endtask

    task automatic rd_reg(input logic [3:0] o, input bit rdy);
        drive(0, 1, 0, {BASE, o}, '0, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(0, 0, 0, '0, '0, rdy);
    endtask

    task automatic pulse_reset();
        // Bus write during reset must be ignored.
        drive(1, 1, 1, {BASE, O_DATA}, 32'hDEAD_BEEF, 1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        check("out_valid", {31'b0, out_valid}, {31'b0, cur_valid});
        check("irq", {31'b0, irq}, {31'b0, cur_irq});
        if (cur_rd) begin
            if (rd_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL read_resp: got %h expected no response queued", Data_BUS_READ);
            end else begin
                check("read_data", Data_BUS_READ, rd_q.pop_front());
            end
        end else begin
            check("read_idle", Data_BUS_READ, 32'h0);
        end
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL out_data: got %h expected no word pending", out_data);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        @(posedge clock);
        #1;
        pulse_reset();
        pulse_reset();
        idle(2, 1);

        // Three words held back, STATUS shows count 3, then drain.
        wr_reg(O_DATA, 32'h11, 0);
        wr_reg(O_DATA, 32'h22, 0);
        wr_reg(O_DATA, 32'h33, 0);
        rd_reg(O_STATUS, 0);
        idle(5, 1);

        // Overflow: nine pushes into eight slots, then clear ovf.
        for (int i = 0; i < 9; i++) wr_reg(O_DATA, 32'h100 + i, 0);
        rd_reg(O_STATUS, 0);
        wr_reg(O_CTRL, 32'h8000_0000, 0);
        rd_reg(O_STATUS, 0);
        idle(DEPTH + 2, 1);

        // Push and pop together while full.
        for (int i = 0; i < DEPTH; i++) wr_reg(O_DATA, 32'h200 + i, 0);
        wr_reg(O_DATA, 32'h2FF, 1);
        rd_reg(O_STATUS, 0);
        idle(DEPTH + 2, 1);

        // Push and pop together while empty.
        wr_reg(O_DATA, 32'h3AA, 1);
        idle(2, 1);

        // Auto-reload timer, TLOAD=3.
        wr_reg(O_TLOAD, 32'd3, 0);
        wr_reg(O_CTRL, 32'h3, 0);
        for (int i = 0; i < 10; i++) rd_reg(O_TVALUE, 0);
        rd_reg(O_STATUS, 0);
        wr_reg(O_CTRL, 32'h8000_0000, 0);
        idle(2, 0);

        // One-shot timer, TLOAD=2.
        wr_reg(O_TLOAD, 32'd2, 0);
        wr_reg(O_CTRL, 32'h1, 0);
        for (int i = 0; i < 6; i++) rd_reg(O_TVALUE, 0);
        rd_reg(O_CTRL, 0);
        pulse_reset();
        idle(2, 0);

        // Reserved offset, foreign base, cs=0 write.
        rd_reg(4'h7, 0);
        drive(0, 1, 0, {6'h00, 4'h1}, '0, 0);
        drive(0, 0, 1, {BASE, O_TLOAD}, 32'h55, 0);
        drive(0, 1, 1, {6'h00, O_TLOAD}, 32'h66, 0);
        rd_reg(O_TLOAD, 0);
        wr_reg(4'h9, 32'hFFFF_FFFF, 0);
        rd_reg(O_STATUS, 0);

        // TLOAD=0 with auto-reload; clear coincident with expiries.
        wr_reg(O_TLOAD, 32'd0, 0);
        wr_reg(O_CTRL, 32'h3, 0);
        for (int i = 0; i < 4; i++) rd_reg(O_TVALUE, 0);
        wr_reg(O_CTRL, 32'h8000_0003, 0);
        rd_reg(O_STATUS, 0);
        wr_reg(O_CTRL, 32'h8000_0000, 0);
        idle(2, 0);

        // Random traffic with a mid-run reset.
        for (int i = 0; i < 400; i++) begin
            bit          c, w, rdy;
            logic [9:0]  a;
            logic [31:0] d;
            if (i == 200) begin
                wr_reg(O_DATA, 32'hCAFE_0001, 0);
                rd_reg(O_STATUS, 0);
                pulse_reset();
            end
            c = ($urandom_range(0, 99) < 70);
            w = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) == 0) a = {6'h15, 4'($urandom_range(0, 15))};
            else                           a = {BASE, 4'($urandom_range(0, 7))};
            d = $urandom;
            if (a[3:0] == O_TLOAD) d = $urandom_range(0, 5);
            if (a[3:0] == O_CTRL)  d = {($urandom_range(0, 3) == 0), 29'b0, 2'($urandom_range(0, 3))};
            rdy = ($urandom_range(0, 2) != 0);
            drive(0, c, w, a, d, rdy);
        end

        idle(DEPTH + 3, 1);
        check("stream_drained", exp_q.size(), 0);
        check("reads_drained", rd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
